vx_bits_insert_pipe: RTL and testbench

Registered, multi-lane bit-field inserter with a valid/ready handshake. Each cycle it accepts one beat of LANES words and splices an S-bit field into every word at bit position POS. The field comes either from the port or from an internal wrapping tag counter. It sits between pipeline stages that must tag or annotate payloads, such as request IDs before a memory arbiter or lane tags before a crossbar. A two-entry skid buffer gives full throughput and a registered output.

---
 rtl/vx_bits_insert_pipe.sv | 75 +++++++
 tb/tb_vx_bits_insert_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vx_bits_insert_pipe.sv
// vx_bits_insert_pipe: per-lane bit-field splicer behind a two-entry skid buffer
module vx_bits_insert_pipe #(
  parameter int N = 1,
  parameter int S = 1,
  parameter int POS = 0,
  parameter int LANES = 1,
  parameter bit AUTO_TAG = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [LANES*N-1:0]     data_in,
  input  logic [LANES*S-1:0]     sel_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [LANES*(N+S)-1:0] data_out
);
  localparam int W = N + S;
  logic [LANES*S-1:0] fld;
  logic [LANES*W-1:0] spl, out_d, skid_d;
  logic out_v, skid_v, in_hs;
  if (POS > N) begin : g_bad_pos
    $error("vx_bits_insert_pipe: POS exceeds N");
  end
  if (AUTO_TAG && LANES > (1 << S)) begin : g_bad_lanes
    $error("vx_bits_insert_pipe: LANES exceeds tag space");
  end
  assign ready_in = !skid_v && !reset;
  assign in_hs = valid_in && ready_in;
  assign valid_out = out_v;
  assign data_out = out_d;
  if (AUTO_TAG) begin : g_tag
    logic [S-1:0] tag;
    always_ff @(posedge clk)
      if (reset) tag <= '0;
      else if (in_hs) tag <= tag + S'(LANES);
    for (genvar i = 0; i < LANES; i++) begin : g_f
      assign fld[i*S +: S] = tag + S'(i);
    end
  end else begin : g_sel
    assign fld = sel_in;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N-1:0] w;
    logic [S-1:0] f;
    assign w = data_in[i*N +: N];
    assign f = fld[i*S +: S];
    if (POS == 0) begin : g_lo
      assign spl[i*W +: W] = {w, f};
    end else if (POS == N) begin : g_hi
      assign spl[i*W +: W] = {f, w};
    end else begin : g_mid
      assign spl[i*W +: W] = {w[N-1:POS], f, w[POS-1:0]};
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (ready_out) skid_v <= 1'b0;
    end else if (in_hs) begin
      if (out_v && !ready_out) skid_v <= 1'b1;
      else out_v <= 1'b1;
    end else if (ready_out) out_v <= 1'b0;
  // payload registers carry no reset; only the valid bits qualify them
  always_ff @(posedge clk)
    if (skid_v) begin
      if (ready_out) out_d <= skid_d;
    end else if (in_hs) begin
      if (out_v && !ready_out) skid_d <= spl;
      else out_d <= spl;
    end
endmodule

// File: tb/tb_vx_bits_insert_pipe.sv
// tb_vx_bits_insert_pipe: directed and random checks of the bit-field inserter
module tb_vx_bits_insert_pipe;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic vin = 0, rout = 0;
  logic [7:0] din = 0;
  logic [3:0] sel = 0;
  logic rdy_a, rdy_b, rdy_c, vo_a, vo_b, vo_c;
  logic [11:0] do_a, do_b, do_c;
  logic vd = 0, rd = 0;
  logic [15:0] dd = 0;
  logic [5:0] sd = 0;
  logic rdy_d, vo_d;
  logic [21:0] do_d;
  int errors = 0, checks = 0;
  logic exp_r [1:10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int exp_o [1:10] = '{0, 1, 1, 1, 1, 2, 3, 4, 5, 0};
  logic [5:0] fexp [5] = '{6'o10, 6'o32, 6'o54, 6'o76, 6'o10};
  logic [7:0] vpat = 8'b11001101;
  logic [11:0] q[$];

  vx_bits_insert_pipe #(.N(8), .S(4), .POS(3), .LANES(1), .AUTO_TAG(0)) u_a (
    .clk(clk), .reset(reset), .valid_in(vin), .ready_in(rdy_a), .data_in(din), .sel_in(sel),
    .valid_out(vo_a), .ready_out(rout), .data_out(do_a));
  vx_bits_insert_pipe #(.N(8), .S(4), .POS(0), .LANES(1), .AUTO_TAG(0)) u_b (
    .clk(clk), .reset(reset), .valid_in(vin), .ready_in(rdy_b), .data_in(din), .sel_in(sel),
    .valid_out(vo_b), .ready_out(rout), .data_out(do_b));
  vx_bits_insert_pipe #(.N(8), .S(4), .POS(8), .LANES(1), .AUTO_TAG(0)) u_c (
    .clk(clk), .reset(reset), .valid_in(vin), .ready_in(rdy_c), .data_in(din), .sel_in(sel),
    .valid_out(vo_c), .ready_out(rout), .data_out(do_c));
  vx_bits_insert_pipe #(.N(8), .S(3), .POS(3), .LANES(2), .AUTO_TAG(1)) u_d (
    .clk(clk), .reset(reset), .valid_in(vd), .ready_in(rdy_d), .data_in(dd), .sel_in(sd),
    .valid_out(vo_d), .ready_out(rd), .data_out(do_d));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] dexp(input logic [2:0] f0, input logic [2:0] f1);
    return (22'(f1) << 14) | (22'(f0) << 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, k, acc, cyc;
    logic prev, stall;
    logic [11:0] prev_d;
    rout = 1;
    rd = 1;
    repeat (2) @(negedge clk);
    chk("rst_vo_a", vo_a, 0);
    chk("rst_rdy_a", rdy_a, 0);
    chk("rst_vo_d", vo_d, 0);
    reset = 0;
    #1 chk("post_rst_rdy", rdy_a, 1);
    vin = 1; din = 8'hA5; sel = 4'hC;
    @(negedge clk);
    din = 8'h3C; sel = 4'h9;
    #1;
    chk("splice_v", vo_a, 1);
    chk("splice_pos3", do_a, 12'hA65);
    chk("splice_pos0", do_b, 12'hA5C);
    chk("splice_posn", do_c, 12'hCA5);
    @(negedge clk);
    vin = 0;
    #1;
    chk("splice2_pos3", do_a, 12'h3CC);
    chk("splice2_pos0", do_b, 12'h3C9);
    chk("splice2_posn", do_c, 12'h93C);
    @(negedge clk);
    #1 chk("idle_v", vo_a, 0);
    nxt = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      vin = nxt <= 5; din = 8'(nxt); sel = 0; rout = !(c >= 2 && c <= 4);
      #1;
      chk("bp_rdy", rdy_a, exp_r[c]);
      chk("bp_v", vo_a, exp_o[c] != 0);
      if (exp_o[c] != 0) chk("bp_d", do_a, exp_o[c]);
      if (vin && rdy_a) nxt++;
    end
    vin = 0; rout = 1;
    k = 0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        prev = vpat[c-1];
        chk("tag_v", vo_d, prev);
        if (prev) begin
          chk("tag_f", do_d, dexp(fexp[k][2:0], fexp[k][5:3]));
          k++;
        end
      end
      vd = c < 8 ? vpat[c] : 1'b0;
    end
    rd = 0; vd = 1;
    repeat (2) @(negedge clk);
    #1 chk("full_rdy", rdy_d, 0);
    reset = 1; vd = 0;
    #1 chk("rst_comb_rdy", rdy_d, 0);
    @(negedge clk);
    chk("rst_mid_vo", vo_d, 0);
    chk("rst_mid_rdy", rdy_d, 0);
    reset = 0; rd = 1;
    #1;
    chk("rst_after_rdy", rdy_d, 1);
    chk("rst_after_vo", vo_d, 0);
    @(negedge clk);
    chk("no_stale", vo_d, 0);
    vd = 1;
    @(negedge clk);
    vd = 0;
    #1;
    chk("tag0_v", vo_d, 1);
    chk("tag0_f", do_d, dexp(3'd0, 3'd1));
    @(negedge clk);
    chk("tag0_done", vo_d, 0);
    acc = 0; cyc = 0; stall = 0; prev_d = 0;
    while (acc < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      vin = 1'($urandom); rout = 1'($urandom); din = 8'($urandom); sel = 4'($urandom);
      #1;
      chk("rnd_v", vo_a, q.size() != 0);
      chk("rnd_rdy", rdy_a, q.size() < 2);
      if (q.size() != 0) chk("rnd_d", do_a, q[0]);
      if (stall) chk("rnd_hold", {vo_a, do_a}, {1'b1, prev_d});
      stall = vo_a && !rout;
      prev_d = do_a;
      if (vo_a && rout && q.size() != 0) void'(q.pop_front());
      if (vin && rdy_a) begin
        q.push_back(((12'(din) >> 3) << 7) | (12'(sel) << 3) | 12'(din & 8'h7));
        acc++;
      end
    end
    chk("rnd_count", acc, 10000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vin = 0; rout = 1;
      #1;
      chk("drain_v", vo_a, q.size() != 0);
      if (q.size() != 0) begin
        chk("drain_d", do_a, q[0]);
        void'(q.pop_front());
      end
    end
    @(negedge clk);
    #1 chk("drained", vo_a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
